// File: rtl/ifu_litebpu_pkg.sv
// Shared widths and state encoding for the IFU static branch predictor.
package ifu_litebpu_pkg;

    localparam int BPU_PC_W    = 32;
    localparam int BPU_XLEN    = 32;
    localparam int BPU_RFIDX_W = 5;

    typedef enum logic [1:0] {
        BPU_IDLE     = 2'd0,
        BPU_WAIT_DEP = 2'd1,
        BPU_REQ      = 2'd2,
        BPU_RD       = 2'd3
    } bpu_state_e;

endpackage

// File: rtl/ifu_litebpu_rs1_fsm.sv
// Fetches the JALR rs1 (xn) operand through the shared regfile read port.
// Waits out a pending write to xn, then holds a request until granted; the data is consumed in RD.
module ifu_litebpu_rs1_fsm
    import ifu_litebpu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic flush_i,
    input  logic xn_dep_i,
    input  logic gnt_i,
    output logic req_o,
    output logic rd_o,
    output logic wait_o
);

    bpu_state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= BPU_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        req_o   = 1'b0;
        rd_o    = 1'b0;
        wait_o  = 1'b0;
        if (flush_i) begin
            state_d = BPU_IDLE;
        end else begin
            case (state_q)
                BPU_IDLE: begin
                    if (start_i) begin
                        wait_o = 1'b1;
                        if (xn_dep_i) begin
                            state_d = BPU_WAIT_DEP;
                        end else begin
                            req_o   = 1'b1;
                            state_d = gnt_i ? BPU_RD : BPU_REQ;
                        end
                    end
                end
                BPU_WAIT_DEP: begin
                    if (!start_i) begin
                        state_d = BPU_IDLE;
                    end else begin
                        wait_o = 1'b1;
                        if (!xn_dep_i) begin
                            req_o   = 1'b1;
                            state_d = gnt_i ? BPU_RD : BPU_REQ;
                        end
                    end
                end
                BPU_REQ: begin
                    if (!start_i) begin
                        state_d = BPU_IDLE;
                    end else begin
                        wait_o = 1'b1;
                        req_o  = 1'b1;
                        if (gnt_i) state_d = BPU_RD;
                    end
                end
                BPU_RD: begin
                    rd_o    = start_i;
                    state_d = BPU_IDLE;
                end
                default: state_d = BPU_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ifu_litebpu.sv
// Static BTFN predictor: branches/JAL/JALR x0/x1 resolve combinationally in the decode cycle.
// JALR xn defers to the rs1 FSM; bpu_wait holds the IR until the prediction pulses or a flush.
module ifu_litebpu
    import ifu_litebpu_pkg::*;
#(
    parameter int PC_W    = BPU_PC_W,
    parameter int XLEN    = BPU_XLEN,
    parameter int RFIDX_W = BPU_RFIDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dec_valid,
    input  logic [PC_W-1:0]    pc,
    input  logic               dec_bjp,
    input  logic               dec_jal,
    input  logic               dec_jalr,
    input  logic [RFIDX_W-1:0] dec_jalr_rs1idx,
    input  logic [XLEN-1:0]    dec_bjp_imm,
    input  logic               flush_req,
    input  logic               x1_dep,
    input  logic               xn_dep,
    input  logic [XLEN-1:0]    rf_x1,
    input  logic               rf_rs1_gnt,
    input  logic [XLEN-1:0]    rf_rs1_rdata,
    output logic               rf_rs1_req,
    output logic [RFIDX_W-1:0] rf_rs1_idx,
    output logic               prdt_valid,
    output logic               prdt_taken,
    output logic [PC_W-1:0]    prdt_pc,
    output logic               bpu_wait
);

    localparam int AW = (PC_W > XLEN) ? PC_W : XLEN;

    logic          kill, active;
    logic          jalr_x0, jalr_x1, jalr_xn;
    logic          fsm_rd, fsm_wait;
    logic [AW-1:0] base_w, target_w;

    // Reset behaves like a flush so no prediction or request escapes while it is held.
    assign kill    = flush_req | rst;
    assign active  = dec_valid & ~kill;
    assign jalr_x0 = dec_jalr & (dec_jalr_rs1idx == RFIDX_W'(0));
    assign jalr_x1 = dec_jalr & (dec_jalr_rs1idx == RFIDX_W'(1));
    assign jalr_xn = dec_jalr & ~jalr_x0 & ~jalr_x1;

    ifu_litebpu_rs1_fsm u_rs1_fsm (
        .clk      (clk),
        .rst      (rst),
        .start_i  (active & jalr_xn),
        .flush_i  (kill),
        .xn_dep_i (xn_dep),
        .gnt_i    (rf_rs1_gnt),
        .req_o    (rf_rs1_req),
        .rd_o     (fsm_rd),
        .wait_o   (fsm_wait)
    );

    assign rf_rs1_idx = rf_rs1_req ? dec_jalr_rs1idx : '0;

    always_comb begin
        base_w = AW'(pc);
        if (jalr_x0)      base_w = '0;
        else if (jalr_x1) base_w = AW'(rf_x1);
        else if (jalr_xn) base_w = AW'(rf_rs1_rdata);
    end

    assign target_w = base_w + AW'($signed(dec_bjp_imm));

    always_comb begin
        prdt_valid = active & (~dec_jalr | jalr_x0 | (jalr_x1 & ~x1_dep) | (jalr_xn & fsm_rd));
        prdt_taken = prdt_valid & (dec_bjp ? dec_bjp_imm[XLEN-1] : (dec_jal | dec_jalr));
        prdt_pc    = prdt_taken ? target_w[PC_W-1:0] : '0;
        bpu_wait   = active & ((jalr_x1 & x1_dep) | fsm_wait);
    end

endmodule
